// File: rtl/core_uart_tx_pkg.sv
// Shared definitions for the UART transmitter: FSM state encoding,
// default clock/baud constants and the bit-period helper.
package core_uart_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    // Chip-level CPU/core clock frequency.
    localparam int unsigned CPU_CLK_FREQ_HZ   = 50_000_000;
    localparam int unsigned DEFAULT_BAUD_RATE = 115_200;

    // Clock cycles per serial bit (integer division, remainder dropped).
    function automatic int unsigned bit_cycles(input int unsigned clk_hz,
                                               input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/core_uart_tx_if.sv
// Bus-side write/status bundle of the UART transmitter.
interface core_uart_tx_if #(
    parameter int unsigned FIFO_DEPTH = 16
) ();

    localparam int unsigned LEVEL_W = $clog2(FIFO_DEPTH) + 1;

    logic               wr_en_i;
    logic [7:0]         wr_data_i;
    logic               full_o;
    logic               empty_o;
    logic [LEVEL_W-1:0] level_o;
    logic               busy_o;
    logic               overflow_o;

    // Register-logic side: issues writes, observes status.
    modport master (
        output wr_en_i, wr_data_i,
        input  full_o, empty_o, level_o, busy_o, overflow_o
    );

    // Transmitter side: accepts writes, reports status.
    modport slave (
        input  wr_en_i, wr_data_i,
        output full_o, empty_o, level_o, busy_o, overflow_o
    );

endinterface

// File: rtl/core_uart_tx_fifo.sv
// Synchronous first-word-fall-through byte FIFO with overflow pulse.
module core_uart_tx_fifo
    import core_uart_tx_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    input  logic                     rd_en,
    output logic [7:0]               rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          overflow_q;
    logic          push;
    logic          pop;

    assign full     = (count_q == (AW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign level    = count_q;
    assign overflow = overflow_q;
    assign rd_data  = mem_q[rd_ptr_q];

    // A full FIFO rejects the write even when a pop frees a slot this cycle.
    assign push = wr_en && !full;
    assign pop  = rd_en && !empty;

    // Storage array, written on every accepted push.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // Pointers (wrap naturally at power-of-two depth), occupancy and overflow pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= wr_en && full;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/core_uart_tx.sv
// 8N1 UART transmitter: byte FIFO feeding a baud-timed framing FSM.
module core_uart_tx
    import core_uart_tx_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = CPU_CLK_FREQ_HZ,
    parameter int unsigned BAUD_RATE   = DEFAULT_BAUD_RATE,
    parameter int unsigned FIFO_DEPTH  = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    core_uart_tx_if.slave bus,
    output logic          txd_o
);

    localparam int unsigned BIT_CYCLES = bit_cycles(CLK_FREQ_HZ, BAUD_RATE);
    localparam int unsigned CNT_W      = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

    tx_state_t  state_q;
    logic [CNT_W-1:0] baud_q;
    logic [2:0] bit_idx_q;
    logic [7:0] shift_q;
    logic       txd_q;
    logic       busy_q;

    logic       fifo_empty;
    logic [7:0] fifo_head;
    logic       bit_done;
    logic       pop_req;

    core_uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .wr_en    (bus.wr_en_i),
        .wr_data  (bus.wr_data_i),
        .rd_en    (pop_req),
        .rd_data  (fifo_head),
        .full     (bus.full_o),
        .empty    (fifo_empty),
        .level    (bus.level_o),
        .overflow (bus.overflow_o)
    );

    assign bus.empty_o = fifo_empty;
    assign bus.busy_o  = busy_q;
    assign txd_o       = txd_q;

    assign bit_done = (baud_q == CNT_W'(BIT_CYCLES - 1));

    // Pop from IDLE, or at the end of STOP so frames run back-to-back.
    assign pop_req = !fifo_empty &&
                     ((state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_done));

    // Framing FSM with baud/bit counters; line and busy are registered from
    // the current state, so both lag the state by one cycle and stay aligned.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            busy_q <= (state_q != ST_IDLE) || !fifo_empty;
            case (state_q)
                ST_START: txd_q <= 1'b0;
                ST_DATA:  txd_q <= shift_q[0];
                default:  txd_q <= 1'b1;
            endcase

            case (state_q)
                ST_IDLE: begin
                    baud_q <= '0;
                    if (pop_req) begin
                        shift_q <= fifo_head;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_done) begin
                        baud_q    <= '0;
                        bit_idx_q <= '0;
                        state_q   <= ST_DATA;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (bit_done) begin
                        baud_q    <= '0;
                        shift_q   <= {1'b0, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 1'b1;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= ST_STOP;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (bit_done) begin
                        baud_q <= '0;
                        if (pop_req) begin
                            shift_q <= fifo_head;
                            state_q <= ST_START;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_core_uart_tx.sv
// Scoreboard bench for core_uart_tx: written bytes are queued as expected
// frames, and a line decoder pops and compares each frame it receives.
module tb_core_uart_tx;

    localparam int unsigned CLK_HZ = 1_000_000;
    localparam int unsigned BAUD   = 100_000;
    localparam int unsigned DEPTH  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic txd;

    core_uart_tx_if #(.FIFO_DEPTH(DEPTH)) bus ();

    core_uart_tx #(
        .CLK_FREQ_HZ (CLK_HZ),
        .BAUD_RATE   (BAUD),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus),
        .txd_o (txd)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          n_frames = 0;
    int          max_lvl = 0;
    int          ovf_cnt = 0;
    bit          mon_busy = 1'b0;
    bit          esc_seen = 1'b0;
    logic [7:0]  exp_q [$];
    logic [7:0]  vec [$];
    int          starts [$];
    string       line_buf = "";

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive vec on consecutive cycles; the first n_accept bytes are expected on the line.
    task automatic burst(input int n_accept);
        for (int i = 0; i < vec.size(); i++) begin
            bus.wr_en_i   = 1'b1;
            bus.wr_data_i = vec[i];
            if (i < n_accept) exp_q.push_back(vec[i]);
            tick();
            if (int'(bus.level_o) > max_lvl) max_lvl = int'(bus.level_o);
            if (bus.overflow_o) ovf_cnt++;
        end
        bus.wr_en_i = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            tick();
            if (int'(bus.level_o) > max_lvl) max_lvl = int'(bus.level_o);
            if (bus.overflow_o) ovf_cnt++;
            if (exp_q.size() == 0 && !bus.busy_o && !mon_busy) begin
                done = 1'b1;
                break;
            end
        end
        check({name, "_drain"}, 32'(done), 32'd1);
    endtask

    // Line decoder: samples every cycle of a frame on the falling clock edge.
    initial begin
        logic       samp [100];
        logic [7:0] b;
        logic [7:0] prev;
        logic [7:0] e;
        int         bad;
        int         t0;
        bit         aborted;
        prev = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst && txd === 1'b0) begin
                mon_busy = 1'b1;
                t0       = cyc;
                aborted  = 1'b0;
                samp[0]  = txd;
                for (int i = 1; i < 100; i++) begin
                    @(negedge clk);
                    if (rst) begin
                        aborted = 1'b1;
                        break;
                    end
                    samp[i] = txd;
                end
                if (!aborted) begin
                    bad = 0;
                    for (int k = 0; k < 10; k++)
                        for (int c = 0; c < 10; c++)
                            if (samp[k*10+c] !== samp[k*10+5]) bad++;
                    for (int k = 0; k < 8; k++) b[k] = samp[(k+1)*10+5];
                    starts.push_back(t0);
                    n_frames++;
                    check("frame_shape", 32'(bad), 32'd0);
                    check("start_bit", 32'(samp[5]), 32'd0);
                    check("stop_bit", 32'(samp[95]), 32'd1);
                    check("frame_pending", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("frame_data", 32'(b), 32'(e));
                    end
                    if (b == 8'h0A) begin
                        $display("UART: %s", line_buf);
                        line_buf = "";
                    end else if (b >= 8'h20 && b < 8'h7F) begin
                        line_buf = $sformatf("%s%c", line_buf, b);
                    end
                    if (prev == 8'h1B && b == 8'h04) begin
                        esc_seen = 1'b1;
                        $display("UART: simulation end requested by escape sequence");
                    end
                    prev = b;
                end
                mon_busy = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: actual=still running required=finished");
        $fatal(1, "global timeout");
    end

    initial begin
        int cnt;
        int f0;
        bus.wr_en_i   = 1'b0;
        bus.wr_data_i = 8'h00;
        rst = 1'b1;
        repeat (3) tick();
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_level", 32'(bus.level_o), 32'd0);
        check("rst_empty", 32'(bus.empty_o), 32'd1);
        check("rst_full", 32'(bus.full_o), 32'd0);
        check("rst_busy", 32'(bus.busy_o), 32'd0);
        check("rst_overflow", 32'(bus.overflow_o), 32'd0);
        rst = 1'b0;
        tick();

        // Single byte 0x41: edge N is the write.
        vec = '{8'h41};
        burst(1);
        check("single_empty_n", 32'(bus.empty_o), 32'd0);
        check("single_level_n", 32'(bus.level_o), 32'd1);
        check("single_txd_n", 32'(txd), 32'd1);
        tick();
        check("single_txd_n1", 32'(txd), 32'd1);
        check("single_level_n1", 32'(bus.level_o), 32'd0);
        tick();
        check("single_txd_n2", 32'(txd), 32'd0);
        cnt = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            cnt++;
            if (!bus.busy_o) break;
        end
        check("single_busy_fall", 32'(cnt), 32'd100);
        wait_drain("single");

        // "Hi\n" back-to-back.
        starts.delete();
        vec = '{8'h48, 8'h69, 8'h0A};
        burst(3);
        wait_drain("string");
        check("string_frames", 32'(starts.size()), 32'd3);
        if (starts.size() == 3) begin
            check("string_gap0", 32'(starts[1] - starts[0]), 32'd100);
            check("string_gap1", 32'(starts[2] - starts[1]), 32'd100);
        end

        // 17 writes from idle: all accepted.
        max_lvl = 0; ovf_cnt = 0; f0 = n_frames;
        vec.delete();
        for (int i = 0; i < 17; i++) vec.push_back(8'(i));
        burst(17);
        wait_drain("ovf17");
        check("ovf17_pulses", 32'(ovf_cnt), 32'd0);
        check("ovf17_peak", 32'(max_lvl), 32'd16);
        check("ovf17_frames", 32'(n_frames - f0), 32'd17);

        // 18 writes: the last is dropped with one overflow pulse.
        max_lvl = 0; ovf_cnt = 0; f0 = n_frames;
        vec.push_back(8'h11);
        burst(17);
        wait_drain("ovf18");
        check("ovf18_pulses", 32'(ovf_cnt), 32'd1);
        check("ovf18_peak", 32'(max_lvl), 32'd16);
        check("ovf18_frames", 32'(n_frames - f0), 32'd17);

        // Push on the exact cycle STOP completes (edge N+101) with level 3.
        vec = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        burst(4);
        check("pp_level_before_wait", 32'(bus.level_o), 32'd3);
        repeat (97) tick();
        check("pp_level_pre", 32'(bus.level_o), 32'd3);
        bus.wr_en_i   = 1'b1;
        bus.wr_data_i = 8'hA4;
        exp_q.push_back(8'hA4);
        tick();
        bus.wr_en_i = 1'b0;
        check("pp_level_post", 32'(bus.level_o), 32'd3);
        wait_drain("pushpop");

        // Reset during DATA bit 4 of 0x55 (write at N, reset edge N+55).
        vec = '{8'h55};
        burst(1);
        repeat (54) tick();
        rst = 1'b1;
        exp_q.delete();
        tick();
        rst = 1'b0;
        check("midrst_txd", 32'(txd), 32'd1);
        check("midrst_level", 32'(bus.level_o), 32'd0);
        check("midrst_busy", 32'(bus.busy_o), 32'd0);
        tick();
        vec = '{8'h31};
        burst(1);
        wait_drain("after_reset");

        // Escape sequence 0x1B 0x04.
        esc_seen = 1'b0;
        vec = '{8'h1B, 8'h04};
        burst(2);
        wait_drain("escape");
        check("escape_seen", 32'(esc_seen), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
